// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the default widths, the opcodes that fetch has to recognise and
// the fetch state encoding used by the top level and the next-pc mux.
package fetch_pkg;

  localparam int ADDR_W_DEFAULT = 10;
  localparam int DATA_W_DEFAULT = 32;

  localparam logic [5:0] OPC_NOP   = 6'b000000;
  localparam logic [5:0] OPC_JUMP  = 6'b000010;
  localparam logic [5:0] OPC_INPUT = 6'b011101;
  localparam logic [5:0] OPC_HALT  = 6'b111111;

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RUN     = 2'd1,
    WAIT_IN = 2'd2,
    HALT    = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_next_pc.sv
// Next program counter selection for the fetch unit.
// Only the RUN state moves the pc: a redirect wins over everything, a stall
// or a HALT opcode holds it, otherwise it advances by one and wraps at the
// top of the address space.
import fetch_pkg::*;

module fetch_next_pc #(
  parameter int         ADDR_W      = ADDR_W_DEFAULT,
  parameter logic [5:0] HALT_OPCODE = OPC_HALT
) (
  input  fetch_state_t      state_i,
  input  logic              stall_i,
  input  logic              jump_valid_i,
  input  logic [ADDR_W-1:0] jump_target_i,
  input  logic [5:0]        opc_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic [ADDR_W-1:0] next_pc_o
);

  // Pick jump target, held pc or incremented pc for the next edge
  always_comb begin
    next_pc_o = pc_i;
    if (state_i == RUN) begin
      if (jump_valid_i) begin
        next_pc_o = jump_target_i;
      end else if (!stall_i && (opc_i != HALT_OPCODE)) begin
        next_pc_o = pc_i + ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the pc, addresses the instruction RAM and
// registers the fetched word for decode. Handles redirects and stalls from
// execute, parks on INPUT instructions until external data is accepted and
// stops permanently on HALT until reset.
// Optional feature: define FETCH_COUNT_EN to add a saturating 32-bit
// fetch_count output counting instructions issued from RAM.
import fetch_pkg::*;

module instruction_fetch_unit #(
  parameter int                ADDR_W      = ADDR_W_DEFAULT,
  parameter int                DATA_W      = DATA_W_DEFAULT,
  parameter logic [ADDR_W-1:0] PC_RESET    = '0,
  parameter logic [5:0]        HALT_OPCODE = OPC_HALT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              jump_valid,
  input  logic [ADDR_W-1:0] jump_target,
  output logic [ADDR_W-1:0] iram_address,
  input  logic [DATA_W-1:0] iram_data,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  output logic              in_req,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] in_word,
  output logic              halted
`ifdef FETCH_COUNT_EN
  ,
  output logic [31:0]       fetch_count
`endif
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              instr_valid_q, instr_valid_d;
  logic              in_req_q, in_req_d;
  logic [DATA_W-1:0] in_word_q, in_word_d;
  logic              halted_q, halted_d;
  logic [5:0]        opc;

  assign opc = iram_data[31:26];

  fetch_next_pc #(
    .ADDR_W      (ADDR_W),
    .HALT_OPCODE (HALT_OPCODE)
  ) u_next_pc (
    .state_i       (state_q),
    .stall_i       (stall),
    .jump_valid_i  (jump_valid),
    .jump_target_i (jump_target),
    .opc_i         (opc),
    .pc_i          (pc_q),
    .next_pc_o     (pc_d)
  );

  // FSM and pipeline-register next state; everything holds unless a state acts
  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    in_req_d      = in_req_q;
    in_word_d     = in_word_q;
    halted_d      = halted_q;
    case (state_q)
      BOOT: begin
        instr_valid_d = 1'b0;
        state_d       = RUN;
      end
      RUN: begin
        if (jump_valid) begin
          instr_valid_d = 1'b0;
        end else if (!stall) begin
          instr_d       = iram_data;
          instr_pc_d    = pc_q;
          instr_valid_d = 1'b1;
          if (opc == HALT_OPCODE) begin
            instr_valid_d = 1'b0;
            halted_d      = 1'b1;
            state_d       = HALT;
          end else if (opc == OPC_INPUT) begin
            in_req_d = 1'b1;
            state_d  = WAIT_IN;
          end
        end
      end
      WAIT_IN: begin
        instr_valid_d = 1'b0;
        if (in_req_q && in_valid) begin
          in_word_d = in_data;
          in_req_d  = 1'b0;
          state_d   = RUN;
        end
      end
      HALT: begin
        instr_valid_d = 1'b0;
        halted_d      = 1'b1;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // State, pc and decode-facing registers; reset clears everything at once
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= BOOT;
      pc_q          <= PC_RESET;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      in_req_q      <= 1'b0;
      in_word_q     <= '0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      in_req_q      <= in_req_d;
      in_word_q     <= in_word_d;
      halted_q      <= halted_d;
    end
  end

  assign iram_address = pc_q;
  assign instr        = instr_q;
  assign instr_pc     = instr_pc_q;
  assign instr_valid  = instr_valid_q;
  assign in_req       = in_req_q;
  assign in_word      = in_word_q;
  assign halted       = halted_q;

`ifdef FETCH_COUNT_EN
  logic [31:0] fetch_count_q;
  logic        fetch_inc;

  assign fetch_inc = (state_q == RUN) && !jump_valid && !stall && (opc != HALT_OPCODE);

  // Count instructions issued from RAM, sticking at the maximum value
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_count_q <= '0;
    end else if (fetch_inc && (fetch_count_q != 32'hFFFF_FFFF)) begin
      fetch_count_q <= fetch_count_q + 32'd1;
    end
  end

  assign fetch_count = fetch_count_q;
`endif

endmodule
